ppu_host_write_sequencer: RTL
=============================

// Module: ppu_host_write_sequencer
// PURPOSE
//  Upstream of the PPU scan/fetch stage. Accepts 32-bit host bus writes (chipselect/write/write_data),
//  decodes header+burst command packets and issues single-cycle write strobes into the five PPU
//  memories (tile buffer, tile graphics, sprite graphics, color palettes, OAM). Holds writes off
//  while the PPU owns the memories (mem_busy = vblank|hsync fetch window) and back-pressures the host.
// PARAMETERS
//  TB_AW   9   tile buffer address width (512 words)
//  TG_AW   11  tile graphics address width (2048 words)
//  SG_AW   11  sprite graphics address width (2048 words)
//  PAL_AW  3   color palette address width (8 entries, 24-bit)
//  OAM_AW  8   OAM address width (256 words)
// PORTS
//  clk                        in   1       system clock
//  reset                      in   1       synchronous, active-low reset
//  chipselect                 in   1       host select
//  write                      in   1       host write strobe
//  write_data                 in   32      host write word
//  waitrequest                out  1       host must hold write while high
//  mem_busy                   in   1       PPU owns memories; no issue this cycle
//  rw_tile_buffer/_tile_graphics/_sprite_graphics/_color_palettes/_OAM  out 1 each  1 = write strobe
//  addr_tile_buffer           out  TB_AW   write address
//  addr_tile_graphics         out  TG_AW   write address
//  addr_sprite_graphics       out  SG_AW   write address
//  addr_color_palettes        out  PAL_AW  write address
//  addr_OAM                   out  OAM_AW  write address
//  write_data_tile_buffer/_tile_graphics/_sprite_graphics/_OAM  out 32 each  write data
//  write_data_color_palettes  out  24      write data (= word[23:0])
//  seq_active                 out  1       high while in DATA or DISCARD
//  bad_target                 out  1       sticky: header with target 5..7 seen; cleared only by reset
// BEHAVIOUR
//  - accept = chipselect & write & ~waitrequest; waitrequest = pending & mem_busy (combinational).
//  - Header word: [31:29] target (0 TB,1 TG,2 SG,3 PAL,4 OAM); [28:20] count N (0..511); [19:0] start addr.
//    Start addr is truncated to target AW.
//  - FSM: IDLE -> header accepted: N=0 stays IDLE; target<=4 -> DATA; target>=5 -> DISCARD + set bad_target.
//    DATA: each accepted word is a data word; remaining--, addr++ mod 2^AW (wraps, no error); remaining hits 0 -> IDLE.
//    DISCARD: accepted words are dropped (no strobe), remaining--; 0 -> IDLE.
//  - Data accept at edge t captures {target,addr,data} into one-entry pending reg (pending=1).
//  - Issue at any edge where pending & ~mem_busy: registered outputs drive exactly one rw_* = 1 with
//    matching addr/data for that one cycle; pending clears unless a new word is accepted the same edge.
//  - Latency: word accepted at edge t, mem_busy low at t+1 -> strobe high t+1..t+2.
//    Sustained 1 word/cycle when mem_busy low.
//  - Cycles with no issue: all rw_* = 0; addr/write_data outputs hold last value.
//  - mem_busy high with pending: waitrequest=1, word retained; mem_busy falls -> issue next edge.
//  - Header accepted while pending: allowed; pending word keeps its captured target/addr.
//  - Reset (reset=0 at an edge): state IDLE, remaining=0, pending=0, all rw_*=0, all addr/write_data=0,
//    bad_target=0, seq_active=0; mid-burst or pending words are dropped.
//  - write without chipselect ignored; reads not supported.
// TESTING
//  - Reset then header {3'd3,9'd2,20'd6}, words 0x00AABBCC,0x00112233, mem_busy=0 -> rw_color_palettes
//    pulses addr 6 data AABBCC, then addr 7 data 112233; returns IDLE.
//  - OAM header start 254, N=4 -> strobes at addr 254,255,0,1 (wrap); seq_active low after 4th accept.
//  - mem_busy=1 during TG burst -> one word pending, waitrequest=1, no rw_*; mem_busy falls ->
//    strobe next cycle, then 1 word/cycle.
//  - Header target 6, N=3, then 3 words -> no rw_* strobes, bad_target=1 sticky, next valid header works.
//  - reset=0 mid SG burst with pending word -> no strobe issued, IDLE; next word is parsed as header.
//  - Header N=0 to TB -> no strobe, stays IDLE; following word treated as header.

Source files
------------

// File: rtl/ppu_host_write_sequencer_if.sv
// Host write bus into the PPU write sequencer.
// Avalon-style write-only slave with waitrequest.
interface ppu_host_write_sequencer_if;
  logic        chipselect;
  logic        write;
  logic [31:0] write_data;
  logic        waitrequest;

  modport master (
    output chipselect,
    output write,
    output write_data,
    input  waitrequest
  );

  modport slave (
    input  chipselect,
    input  write,
    input  write_data,
    output waitrequest
  );
endinterface

// File: rtl/ppu_host_write_sequencer.sv
// Parses header+burst host packets and issues
// single-cycle write strobes into the PPU memories.
module ppu_host_write_sequencer #(
  parameter int TB_AW  = 9,
  parameter int TG_AW  = 11,
  parameter int SG_AW  = 11,
  parameter int PAL_AW = 3,
  parameter int OAM_AW = 8
) (
  input  logic                clk,
  input  logic                reset,
  ppu_host_write_sequencer_if.slave host,
  input  logic                mem_busy,
  output logic                rw_tile_buffer,
  output logic                rw_tile_graphics,
  output logic                rw_sprite_graphics,
  output logic                rw_color_palettes,
  output logic                rw_OAM,
  output logic [TB_AW-1:0]    addr_tile_buffer,
  output logic [TG_AW-1:0]    addr_tile_graphics,
  output logic [SG_AW-1:0]    addr_sprite_graphics,
  output logic [PAL_AW-1:0]   addr_color_palettes,
  output logic [OAM_AW-1:0]   addr_OAM,
  output logic [31:0]         write_data_tile_buffer,
  output logic [31:0]         write_data_tile_graphics,
  output logic [31:0]         write_data_sprite_graphics,
  output logic [31:0]         write_data_OAM,
  output logic [23:0]         write_data_color_palettes,
  output logic                seq_active,
  output logic                bad_target
);

  localparam int M1  = (TB_AW > TG_AW) ? TB_AW : TG_AW;
  localparam int M2  = (M1 > SG_AW) ? M1 : SG_AW;
  localparam int M3  = (M2 > PAL_AW) ? M2 : PAL_AW;
  localparam int MAW = (M3 > OAM_AW) ? M3 : OAM_AW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_DISC
  } state_e;

  state_e          state_q;
  logic [8:0]      rem_q;
  logic [2:0]      tgt_q;
  logic [MAW-1:0]  addr_q;
  logic            pend_q;
  logic [2:0]      pend_tgt_q;
  logic [MAW-1:0]  pend_addr_q;
  logic [31:0]     pend_data_q;
  logic [MAW-1:0]  cap_addr;

  logic        accept;
  logic        issue;
  logic [31:0] wd;
  logic [2:0]  h_tgt;
  logic [8:0]  h_cnt;
  logic        h_bad;

  assign host.waitrequest = pend_q & mem_busy;

  assign accept = host.chipselect & host.write &
                  ~host.waitrequest;
  assign issue  = pend_q & ~mem_busy;
  assign wd     = host.write_data;
  assign h_tgt  = wd[31:29];
  assign h_cnt  = wd[28:20];
  assign h_bad  = (h_tgt >= 3'd5);

  assign seq_active = (state_q != S_IDLE);

  // Burst address counts in MAW bits; only the
  // target's low AW bits are captured, so it wraps.
  always_comb begin
    cap_addr = '0;
    unique case (tgt_q)
      3'd0: cap_addr[TB_AW-1:0]  = addr_q[TB_AW-1:0];
      3'd1: cap_addr[TG_AW-1:0]  = addr_q[TG_AW-1:0];
      3'd2: cap_addr[SG_AW-1:0]  = addr_q[SG_AW-1:0];
      3'd3: cap_addr[PAL_AW-1:0] = addr_q[PAL_AW-1:0];
      3'd4: cap_addr[OAM_AW-1:0] = addr_q[OAM_AW-1:0];
      default: cap_addr = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q                    <= S_IDLE;
      rem_q                      <= '0;
      tgt_q                      <= '0;
      addr_q                     <= '0;
      pend_q                     <= 1'b0;
      pend_tgt_q                 <= '0;
      pend_addr_q                <= '0;
      pend_data_q                <= '0;
      bad_target                 <= 1'b0;
      rw_tile_buffer             <= 1'b0;
      rw_tile_graphics           <= 1'b0;
      rw_sprite_graphics         <= 1'b0;
      rw_color_palettes          <= 1'b0;
      rw_OAM                     <= 1'b0;
      addr_tile_buffer           <= '0;
      addr_tile_graphics         <= '0;
      addr_sprite_graphics       <= '0;
      addr_color_palettes        <= '0;
      addr_OAM                   <= '0;
      write_data_tile_buffer     <= '0;
      write_data_tile_graphics   <= '0;
      write_data_sprite_graphics <= '0;
      write_data_OAM             <= '0;
      write_data_color_palettes  <= '0;
    end else begin
      rw_tile_buffer     <= 1'b0;
      rw_tile_graphics   <= 1'b0;
      rw_sprite_graphics <= 1'b0;
      rw_color_palettes  <= 1'b0;
      rw_OAM             <= 1'b0;

      if (issue) begin
        pend_q <= 1'b0;
        unique case (pend_tgt_q)
          3'd0: begin
            rw_tile_buffer <= 1'b1;
            addr_tile_buffer <=
              pend_addr_q[TB_AW-1:0];
            write_data_tile_buffer <= pend_data_q;
          end
          3'd1: begin
            rw_tile_graphics <= 1'b1;
            addr_tile_graphics <=
              pend_addr_q[TG_AW-1:0];
            write_data_tile_graphics <= pend_data_q;
          end
          3'd2: begin
            rw_sprite_graphics <= 1'b1;
            addr_sprite_graphics <=
              pend_addr_q[SG_AW-1:0];
            write_data_sprite_graphics <= pend_data_q;
          end
          3'd3: begin
            rw_color_palettes <= 1'b1;
            addr_color_palettes <=
              pend_addr_q[PAL_AW-1:0];
            write_data_color_palettes <=
              pend_data_q[23:0];
          end
          3'd4: begin
            rw_OAM <= 1'b1;
            addr_OAM <= pend_addr_q[OAM_AW-1:0];
            write_data_OAM <= pend_data_q;
          end
          default: ;
        endcase
      end

      // A capture on the same edge overrides the clear.
      if (accept) begin
        unique case (state_q)
          S_IDLE: begin
            tgt_q  <= h_tgt;
            rem_q  <= h_cnt;
            addr_q <= wd[MAW-1:0];
            if (h_bad)
              bad_target <= 1'b1;
            if (h_cnt != 9'd0)
              state_q <= h_bad ? S_DISC : S_DATA;
          end
          S_DATA: begin
            pend_q      <= 1'b1;
            pend_tgt_q  <= tgt_q;
            pend_addr_q <= cap_addr;
            pend_data_q <= wd;
            rem_q       <= rem_q - 9'd1;
            addr_q      <= addr_q + 1'b1;
            if (rem_q == 9'd1)
              state_q <= S_IDLE;
          end
          S_DISC: begin
            rem_q <= rem_q - 9'd1;
            if (rem_q == 9'd1)
              state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
